uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_sync.sv | 34 +++
 rtl/uart_rx.sv | 158 +++++++++++++++
 tb/tb_uart_rx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART divisor sets and FSM state encoding
package uart_pkg;

    localparam int PROD_T_DIV_BIT    = 13;
    localparam int PROD_T_DIV_0      = 5207;
    localparam int PROD_T_DIV_HALF_0 = 2603;
    localparam int PROD_T_DIV_1      = 2603;
    localparam int PROD_T_DIV_HALF_1 = 1301;

    // Short divisors so a whole frame fits in a couple hundred clocks.
    localparam int SIM_T_DIV_BIT     = 4;
    localparam int SIM_T_DIV_0       = 15;
    localparam int SIM_T_DIV_HALF_0  = 7;
    localparam int SIM_T_DIV_1       = 7;
    localparam int SIM_T_DIV_HALF_1  = 3;

    localparam int FRAME_DATA_BITS   = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAD   = 3'd3,
        ST_STOP  = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-FF synchronizer and falling-edge detector for the RX line
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rxd_async,
    output logic rxd_sync,
    output logic rxd_fall
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;
    logic       prev_q;
    logic       prev_d;

    always_comb begin
        sync_d = {sync_q[0], rxd_async};
        prev_d = sync_q[1];
    end

    // Reset to the idle-high level so deasserting rst never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rxd_sync = sync_q[1];
    assign rxd_fall = prev_q & ~sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: start, 8 data LSB first, pad, stop; two selectable rates
module uart_rx
    import uart_pkg::*;
#(
    parameter int T_DIV_0      = PROD_T_DIV_0,
    parameter int T_DIV_HALF_0 = PROD_T_DIV_HALF_0,
    parameter int T_DIV_1      = PROD_T_DIV_1,
    parameter int T_DIV_HALF_1 = PROD_T_DIV_HALF_1,
    parameter int T_DIV_BIT    = PROD_T_DIV_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baudrate,
    input  logic       uart_rxd,
    output logic [7:0] dout,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [T_DIV_BIT-1:0] FULL_0 = T_DIV_BIT'(T_DIV_0);
    localparam logic [T_DIV_BIT-1:0] HALF_0 = T_DIV_BIT'(T_DIV_HALF_0);
    localparam logic [T_DIV_BIT-1:0] FULL_1 = T_DIV_BIT'(T_DIV_1);
    localparam logic [T_DIV_BIT-1:0] HALF_1 = T_DIV_BIT'(T_DIV_HALF_1);
    localparam logic [3:0]           LAST_BIT = 4'(FRAME_DATA_BITS - 1);

    logic rxd_s;
    logic rxd_fall;

    uart_rx_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .rxd_async (uart_rxd),
        .rxd_sync  (rxd_s),
        .rxd_fall  (rxd_fall)
    );

    uart_state_e          state_q, state_d;
    logic [T_DIV_BIT-1:0] div_q, div_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           dout_q, dout_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 baud_q, baud_d;

    logic [T_DIV_BIT-1:0] full_last;
    logic [T_DIV_BIT-1:0] half_last;
    logic                 full_hit;

    // Rate is taken from the latched copy so mid-frame changes on baudrate are ignored.
    always_comb begin
        full_last = baud_q ? FULL_1 : FULL_0;
        half_last = baud_q ? HALF_1 : HALF_0;
        full_hit  = (div_q == full_last);
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        dout_d      = dout_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
        baud_d      = baud_q;

        unique case (state_q)
            ST_IDLE: begin
                div_d = '0;
                if (rxd_fall) begin
                    state_d = ST_START;
                    baud_d  = baudrate;
                end
            end
            ST_START: begin
                if (div_q == half_last) begin
                    div_d = '0;
                    if (rxd_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end else begin
                    div_d = div_q + T_DIV_BIT'(1);
                end
            end
            ST_DATA: begin
                if (full_hit) begin
                    div_d   = '0;
                    shift_d = {rxd_s, shift_q[7:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_PAD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    div_d = div_q + T_DIV_BIT'(1);
                end
            end
            ST_PAD: begin
                if (full_hit) begin
                    div_d   = '0;
                    state_d = ST_STOP;
                end else begin
                    div_d = div_q + T_DIV_BIT'(1);
                end
            end
            ST_STOP: begin
                if (full_hit) begin
                    div_d   = '0;
                    state_d = ST_IDLE;
                    if (rxd_s) begin
                        dout_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + T_DIV_BIT'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                div_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            baud_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            dout_q      <= dout_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            baud_q      <= baud_d;
        end
    end

    assign dout      = dout_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with the short divisor set
module tb_uart_rx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baudrate = 1'b0;
    logic       uart_rxd = 1'b1;
    logic [7:0] dout;
    logic       valid;
    logic       frame_err;
    logic       busy;

    uart_rx #(
        .T_DIV_0      (SIM_T_DIV_0),
        .T_DIV_HALF_0 (SIM_T_DIV_HALF_0),
        .T_DIV_1      (SIM_T_DIV_1),
        .T_DIV_HALF_1 (SIM_T_DIV_HALF_1),
        .T_DIV_BIT    (SIM_T_DIV_BIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .baudrate  (baudrate),
        .uart_rxd  (uart_rxd),
        .dout      (dout),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t       sbq[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] model_dout = 8'h00;
    bit         prev_valid = 1'b0;
    bit         prev_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int bit_clks(input bit b);
        return b ? (SIM_T_DIV_1 + 1) : (SIM_T_DIV_0 + 1);
    endfunction

    function automatic int half_clks(input bit b);
        return b ? SIM_T_DIV_HALF_1 : SIM_T_DIV_HALF_0;
    endfunction

    // Drive frame bits LSB first, each held one bit period of rate b.
    task automatic drive_bits(input bit b, input logic [10:0] bits, input int nbits, input bit toggle);
        for (int i = 0; i < nbits; i++) begin
            uart_rxd = bits[i];
            if (toggle && i == 4) baudrate = ~baudrate;
            repeat (bit_clks(b)) @(negedge clk);
        end
    endtask

    // Expected pulse: 2 sync flops + edge flop, half bit to mid-start, then ten full bits.
    task automatic send(input logic [7:0] d, input bit b, input bit pad, input bit stop, input bit toggle);
        exp_t e;
        baudrate = b;
        e.at     = cyc + 4 + half_clks(b) + 10 * bit_clks(b);
        e.is_err = !stop;
        e.data   = stop ? d : model_dout;
        if (stop) model_dout = d;
        sbq.push_back(e);
        drive_bits(b, {stop, pad, d, 1'b0}, 11, toggle);
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while ((sbq.size() != 0 || busy) && i < 600) begin
            @(negedge clk);
            i++;
        end
        chk({name, "_pending"}, sbq.size(), 0);
        chk({name, "_busy"}, {31'b0, busy}, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("valid_and_err", {31'b0, valid & frame_err}, 0);
            chk("valid_one_cycle", {31'b0, valid & prev_valid}, 0);
            chk("err_one_cycle", {31'b0, frame_err & prev_err}, 0);
            if (valid || frame_err) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b dout=0x%0h, want no pulse (cycle %0d)",
                             valid, frame_err, dout, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("pulse_kind", {31'b0, frame_err}, {31'b0, e.is_err});
                    chk("dout", {24'b0, dout}, {24'b0, e.data});
                    chk("latency", cyc, e.at);
                end
            end
        end
        prev_valid = valid;
        prev_err   = frame_err;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         rb;
        bit         rstop;
        logic [7:0] rd;

        repeat (3) @(negedge clk);
        chk("rst_dout", {24'b0, dout}, 0);
        chk("rst_valid", {31'b0, valid}, 0);
        chk("rst_frame_err", {31'b0, frame_err}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        send(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        drain("a5");

        send(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        send(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0);
        send(8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        drain("b2b");

        baudrate = 1'b0;
        uart_rxd = 1'b0;
        repeat (4) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_busy", {31'b0, busy}, 0);
        chk("glitch_dout", {24'b0, dout}, {24'b0, model_dout});

        send(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        chk("held_low_busy", {31'b0, busy}, 0);
        chk("held_low_dout", {24'b0, dout}, {24'b0, model_dout});
        uart_rxd = 1'b1;
        repeat (10) @(negedge clk);
        drain("ferr");

        drive_bits(1'b0, {2'b11, 8'hA5, 1'b0}, 4, 1'b0);
        uart_rxd = 1'b0;
        repeat (5) @(negedge clk);
        chk("d3_busy", {31'b0, busy}, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_dout", {24'b0, dout}, 0);
        chk("midrst_valid", {31'b0, valid}, 0);
        chk("midrst_frame_err", {31'b0, frame_err}, 0);
        chk("midrst_busy", {31'b0, busy}, 0);
        uart_rxd   = 1'b1;
        model_dout = 8'h00;
        rst        = 1'b0;
        repeat (40) @(negedge clk);
        chk("post_rst_busy", {31'b0, busy}, 0);
        send(8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
        drain("r81");

        send(8'h0F, 1'b0, 1'b0, 1'b1, 1'b1);
        drain("toggle");

        for (int k = 0; k < 10; k++) begin
            rd    = 8'($urandom);
            rb    = 1'($urandom_range(0, 1));
            rstop = ($urandom_range(0, 3) != 0);
            send(rd, rb, 1'($urandom_range(0, 1)), rstop, 1'($urandom_range(0, 1)));
            uart_rxd = 1'b1;
            repeat (rstop ? $urandom_range(0, 5) : $urandom_range(3, 8)) @(negedge clk);
        end
        drain("random");
        chk("final_dout", {24'b0, dout}, {24'b0, model_dout});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
